// File: rtl/dmem_pkg.sv
// Shared types and widths for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_byte_array.sv
// Little-endian byte storage with one word-wide write port and a combinational word read.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 8,
    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Deliberately unreset so the contents survive a pipeline reset.
    logic [7:0] memory [4*DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[{idx_i, 2'd0}] <= wdata_i[7:0];
            memory[{idx_i, 2'd1}] <= wdata_i[15:8];
            memory[{idx_i, 2'd2}] <= wdata_i[23:16];
            memory[{idx_i, 2'd3}] <= wdata_i[31:24];
        end
    end

    assign rdata_o = {memory[{idx_i, 2'd3}], memory[{idx_i, 2'd2}],
                      memory[{idx_i, 2'd1}], memory[{idx_i, 2'd0}]};

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with req/ack handshake and pipeline stall output.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 8,
    parameter int unsigned LATENCY     = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [WORD_W-1:3]  unused_hi;
    logic [WORD_W-1:2]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [WORD_W-1:0]  rdata_q;
    logic               err_q;
    logic               in_range;
    logic               access;
    logic               mem_we;
    logic [WORD_W-1:0]  mem_rdata;
    logic               unused_addr;

    // Byte offset is ignored; only the word address is latched.
    assign unused_addr = ^addr_i[1:0];
    assign unused_hi   = '0;

    assign in_range = (addr_q[WORD_W-1:ADDR_W+2] == '0);
    assign access   = (state_q == StWait) && (cnt_q == '0);
    assign mem_we   = access && we_q && in_range;

    dmem_byte_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (addr_q[ADDR_W+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = StWait;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i[WORD_W-1:2];
                wdata_q <= wdata_i;
            end
            if (access && !we_q) begin
                rdata_q <= in_range ? mem_rdata : '0;
            end
            if (access) begin
                err_q <= ~in_range;
            end else if (state_q == StAck) begin
                err_q <= 1'b0;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = (state_q == StAck);
    assign err_o   = err_q;
    assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY=10 and LATENCY=1.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, req, we, ack, err, stall;
    logic [31:0] addr, wdata, rdata;
    logic        rst1_n, req1, we1, ack1, err1, stall1;
    logic [31:0] addr1, wdata1, rdata1;

    int tests = 0;
    int fails = 0;

    logic [31:0] pre [8] = '{32'h0000_0005, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                             32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(8), .LATENCY(10)) dut (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .ack_o(ack), .err_o(err), .stall_o(stall)
    );

    dmem_responder #(.DEPTH_WORDS(8), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst1_n), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .rdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
    );

    function automatic logic [31:0] mem_word(input int i);
        return {dut.u_array.memory[4*i+3], dut.u_array.memory[4*i+2],
                dut.u_array.memory[4*i+1], dut.u_array.memory[4*i]};
    endfunction

    // One full transaction; returns ack cycle (-1 on timeout) counted from the accepting edge.
    task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output int stalls, output logic [31:0] rd,
                       output logic e, output logic st_ack);
        cyc = -1; stalls = 0; rd = 'x; e = 'x; st_ack = 'x;
        @(negedge clk);
        if (sel) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else     begin req  = 1; we  = w; addr  = a; wdata  = d; end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (sel ? ack1 : ack) begin
                cyc = n;
                rd = sel ? rdata1 : rdata;
                e = sel ? err1 : err;
                st_ack = sel ? stall1 : stall;
                break;
            end
            if (sel ? stall1 : stall) stalls++;
        end
        if (sel) req1 = 0; else req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0; rst1_n = 0; req = 0; we = 0; addr = 0; wdata = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (dut.state_q !== StIdle) begin fails++; $display("FAIL reset_state got %0d want 0", dut.state_q); end
        rst_n = 1; rst1_n = 1;
        @(negedge clk);
    endtask

    task automatic test_preload;
        int c, s; logic [31:0] rd; logic e, sa;
        for (int i = 0; i < 8; i++) txn(0, 1, 32'(4*i), pre[i], c, s, rd, e, sa);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem_word(i) !== pre[i]) begin
                fails++; $display("FAIL preload_w%0d got %h want %h", i, mem_word(i), pre[i]);
            end
        end
        txn(1, 1, 32'h0, 32'h1122_3344, c, s, rd, e, sa);
        txn(1, 1, 32'h4, 32'h5566_7788, c, s, rd, e, sa);
    endtask

    task automatic test_load;
        int c, s; logic [31:0] rd; logic e, sa;
        txn(0, 0, 32'h0, 32'h0, c, s, rd, e, sa);
        tests++; if (c != 11) begin fails++; $display("FAIL load_ack_cycle got %0d want 11", c); end
        tests++; if (s != 10) begin fails++; $display("FAIL load_stall_cycles got %0d want 10", s); end
        tests++; if (sa !== 1'b0) begin fails++; $display("FAIL load_stall_at_ack got %b want 0", sa); end
        tests++; if (rd !== 32'h5) begin fails++; $display("FAIL load_rdata got %h want 5", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL load_err got %b want 0", e); end
    endtask

    task automatic test_store_load;
        int c, s; logic [31:0] rd; logic e, sa; logic [31:0] bytes;
        txn(0, 1, 32'h0C, 32'hDEAD_BEEF, c, s, rd, e, sa);
        tests++; if (c != 11) begin fails++; $display("FAIL store_ack_cycle got %0d want 11", c); end
        tests++; if (rd !== 32'h5) begin fails++; $display("FAIL store_rdata_held got %h want 5", rd); end
        bytes = {dut.u_array.memory[12], dut.u_array.memory[13],
                 dut.u_array.memory[14], dut.u_array.memory[15]};
        tests++; if (bytes !== 32'hEFBE_ADDE) begin fails++; $display("FAIL store_bytes got %h want efbeadde", bytes); end
        txn(0, 0, 32'h0C, 32'h0, c, s, rd, e, sa);
        tests++; if (c != 11) begin fails++; $display("FAIL reload_ack_cycle got %0d want 11", c); end
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL reload_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_latched;
        int acks = 0; int first = -1;
        @(negedge clk);
        req = 1; we = 1; addr = 32'h08; wdata = 32'h1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 3) begin addr = 32'h04; wdata = 32'h99; we = 0; req = 0; end
            if (ack) begin acks++; if (first < 0) first = n; end
        end
        tests++; if (acks != 1) begin fails++; $display("FAIL latched_ack_count got %0d want 1", acks); end
        tests++; if (first != 11) begin fails++; $display("FAIL latched_ack_cycle got %0d want 11", first); end
        tests++; if (mem_word(2) !== 32'h1) begin fails++; $display("FAIL latched_w8 got %h want 1", mem_word(2)); end
        tests++; if (mem_word(1) !== 32'h1111_1111) begin fails++; $display("FAIL latched_w4 got %h want 11111111", mem_word(1)); end
        tests++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL latched_rdata got %h want deadbeef", rdata); end
    endtask

    task automatic test_out_of_range;
        int c, s, diffs; logic [31:0] rd; logic e, sa; logic [7:0] snap [32];
        for (int i = 0; i < 32; i++) snap[i] = dut.u_array.memory[i];
        txn(0, 1, 32'h40, 32'hFFFF_FFFF, c, s, rd, e, sa);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_store_err got %b want 1", e); end
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL oor_store_rdata got %h want deadbeef", rd); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL oor_err_clear got %b want 0", err); end
        txn(0, 0, 32'h40, 32'h0, c, s, rd, e, sa);
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL oor_load_err got %b want 1", e); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_load_rdata got %h want 0", rd); end
        tests++; if (c != 11) begin fails++; $display("FAIL oor_ack_cycle got %0d want 11", c); end
        diffs = 0;
        for (int i = 0; i < 32; i++) if (dut.u_array.memory[i] !== snap[i]) diffs++;
        tests++; if (diffs != 0) begin fails++; $display("FAIL oor_mem_untouched got %0d changed bytes want 0", diffs); end
    endtask

    task automatic test_latency1;
        int n1 = -1, n2 = -1, acks = 0;
        logic [31:0] r1 = 'x, r2 = 'x;
        state_e st_a = StAck, st_b = StAck;
        logic stall_a = 1'bx;
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 32'h0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n1 > 0 && n == n1 + 1) begin st_a = dut1.state_q; stall_a = stall1; end
            if (n1 > 0 && n == n1 + 2) st_b = dut1.state_q;
            if (ack1) begin
                acks++;
                if (n1 < 0) begin n1 = n; r1 = rdata1; addr1 = 32'h4; end
                else begin n2 = n; r2 = rdata1; req1 = 0; end
            end
        end
        req1 = 0;
        tests++; if (n1 != 2) begin fails++; $display("FAIL lat1_first_ack got %0d want 2", n1); end
        tests++; if (n2 != 5) begin fails++; $display("FAIL lat1_second_ack got %0d want 5", n2); end
        tests++; if (acks != 2) begin fails++; $display("FAIL lat1_ack_count got %0d want 2", acks); end
        tests++; if (r1 !== 32'h1122_3344) begin fails++; $display("FAIL lat1_rdata0 got %h want 11223344", r1); end
        tests++; if (r2 !== 32'h5566_7788) begin fails++; $display("FAIL lat1_rdata4 got %h want 55667788", r2); end
        tests++; if (st_a !== StIdle || stall_a !== 1'b1) begin
            fails++; $display("FAIL lat1_idle_gap got state %0d stall %b want 0 1", st_a, stall_a);
        end
        tests++; if (st_b !== StWait) begin fails++; $display("FAIL lat1_reaccept got %0d want 1", st_b); end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        @(negedge clk);
        req = 1; we = 1; addr = 32'h10; wdata = 32'hCAFE_F00D;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rstmid_ack got %b want 0", ack); end
        tests++; if (stall !== req) begin fails++; $display("FAIL rstmid_stall got %b want %b", stall, req); end
        tests++; if (dut.state_q !== StIdle) begin fails++; $display("FAIL rstmid_state got %0d want 0", dut.state_q); end
        repeat (2) @(negedge clk);
        req = 0;
        rst_n = 1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL rstmid_no_ack got %0d want 0", acks); end
        tests++; if (mem_word(4) !== 32'h4444_4444) begin fails++; $display("FAIL rstmid_mem got %h want 44444444", mem_word(4)); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rstmid_rdata got %h want 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_load();
        test_store_load();
        test_latched();
        test_out_of_range();
        test_latency1();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined CPU's MEM stage.
- The MEM stage issues load and store requests. This block answers each one after a fixed, programmable latency, using a req/ack handshake.
- It drives stall_o so the hazard logic can freeze the pipeline while a request is outstanding.
- Storage is a little-endian byte array, so the bench can preload it and dump it word by word.

Parameters:
- DEPTH_WORDS, 8, number of 32-bit words stored (byte array of 4*DEPTH_WORDS entries, named memory).
- LATENCY, 10, clock edges from request acceptance to memory access and ack; legal range is 1 to 255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid, level-held by the MEM stage.
- we_i  in  1  1 = store word, 0 = load word.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid while ack_o=1 and holds afterwards.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  out-of-range address flag; valid with ack_o.
- stall_o  out  1  combinational: req_i & ~ack_o.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, cnt=0, ack_o=0, err_o=0, rdata_o=0, latched request cleared.
  - memory is NOT reset; the bench preloads it.
  - Reset mid-transaction aborts it with no memory write and no ack.
- Address decode:
  - word index = addr_i[ADDR_W+1:2], where ADDR_W = clog2(DEPTH_WORDS); addr_i[1:0] is ignored.
  - In range means addr_i[31:ADDR_W+2] == 0.
- Byte order: word = {memory[4i+3], memory[4i+2], memory[4i+1], memory[4i]}.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: when req_i=1 at an edge, latch we_i/addr_i/wdata_i, load cnt=LATENCY-1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt==0 at an edge, perform the access and go to ACK with ack_o=1. Otherwise cnt decrements.
    - Store: write 4 bytes.
    - Load: rdata_o gets the word.
    - Out of range: store dropped, load returns 0, err_o=1.
  - ACK: ack_o=1 for exactly this one cycle; the next edge returns to IDLE, ack_o=0, err_o=0.
- Latency: request accepted at edge E0, access at edge E0+LATENCY, ack_o high for the cycle after that edge. LATENCY=1 gives ack in the cycle after E1.
- Input changes after acceptance are ignored; the latched values are used.
- req_i dropped during WAIT: the transaction still completes and ack still pulses.
- Back-to-back: if req_i=1 in the first IDLE cycle after ACK, that is a new transaction. The requester must deassert req_i or present the next request.
- req_i is never sampled in WAIT or ACK, so at most one transaction is outstanding.
- stall_o=1 from request assertion through the cycle before ack. It drops in the ack cycle so the pipeline advances on that edge.
- rdata_o is updated only by loads. Stores and out-of-range stores leave it unchanged.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - WORD_W=32;
  - the LATENCY counter width, 8 bits.
- One natural sub-module: dmem_byte_array (byte storage with word-wide little-endian read and write port, no reset).
- The FSM, counter and latch live in the top level.

Test Plan:
- Reset: assert rst_i=0 mid-cycle while in WAIT.
  - Required: ack_o=0, stall_o=req_i, state IDLE immediately, memory word unchanged.
- Load: preload memory[0]=8'h05, then LATENCY=10, req_i=1, we_i=0, addr_i=0.
  - Required: stall_o=1 for 10 cycles, ack_o pulse in the 11th cycle, rdata_o=5, err_o=0.
- Store then load: store 32'hDEADBEEF to 0x0C, then load 0x0C.
  - Required: memory[12..15]=EF,BE,AD,DE, load rdata_o=32'hDEADBEEF, two acks 11 cycles apart each.
- Latched inputs and dropped request: change addr_i to 0x04 and drop req_i during WAIT of a store to 0x08 with wdata 32'h1.
  - Required: word 0x08=1, word 0x04 unchanged, ack still pulses once.
- Out of range: load and store at 0x40 with DEPTH_WORDS=8.
  - Required: err_o=1 with ack, load rdata_o=0, no memory byte modified.
- LATENCY=1: back-to-back loads of 0x00 and 0x04 with req_i held high.
  - Required: ack in the cycle after E1; second request accepted in the IDLE cycle after ACK; second ack 3 cycles after the first.
